alu_op_sequencer: RTL

- Control sequencer directly upstream of the register/bus/adder datapath.
- Accepts a 2-bit micro-opcode with a start/done handshake.
- Drives the datapath's register-in strobes (RAin, RBin, RZin) and bus-out selects (RAout, RBout, RZout) one micro-step at a time.
- Guarantees at most one bus driver per cycle and inserts programmable stall cycles between steps.

---
 rtl/alu_op_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Micro-step control sequencer for the register/bus/adder datapath.
// Define SEQ_WRITEBACK_EN to enable the ADD writeback step (T2/W2 and RZout).
module alu_op_sequencer #(
   parameter int STALL_CYCLES = 0
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       start,
   input  logic [1:0] op,
   output logic       busy,
   output logic       done,
   output logic       RAin,
   output logic       RBin,
   output logic       RZin,
   output logic       RAout,
   output logic       RBout,
   output logic       RZout
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      W1   = 3'd2,
      T2   = 3'd3,
      W2   = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   localparam logic       STALL_EN   = (STALL_CYCLES > 0) ? 1'b1 : 1'b0;
   localparam logic [3:0] STALL_LOAD = (STALL_CYCLES > 0) ? 4'(STALL_CYCLES - 1) : 4'd0;
`ifdef SEQ_WRITEBACK_EN
   localparam logic       WB_EN      = 1'b1;
`else
   localparam logic       WB_EN      = 1'b0;
`endif

   state_t     state_r, state_n_s;
   logic [1:0] op_r, op_n_s;
   logic [3:0] cnt_r, cnt_n_s;
   logic       wb_add_s;

   logic busy_s, done_s, rain_s, rbin_s, rzin_s, raout_s, rbout_s;
   logic busy_r, done_r, rain_r, rbin_r, rzin_r, raout_r, rbout_r;

   assign wb_add_s = WB_EN & (op_r == OP_ADD);

   // Next-state, opcode latch and stall counter logic.
   always_comb begin
      state_n_s = state_r;
      op_n_s    = op_r;
      cnt_n_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               op_n_s = op;
               if (op == OP_NOP) begin
                  state_n_s = DONE;
               end else begin
                  state_n_s = T1;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         T1: begin
            if (STALL_EN) begin
               state_n_s = W1;
               cnt_n_s   = STALL_LOAD;
            end else if (wb_add_s) begin
               state_n_s = T2;
            end else begin
               state_n_s = DONE;
            end
         end
         W1: begin
            if (cnt_r == 4'd0) begin
               state_n_s = wb_add_s ? T2 : DONE;
            end else begin
               cnt_n_s = cnt_r - 4'd1;
            end
         end
         T2: begin
            if (STALL_EN) begin
               state_n_s = W2;
               cnt_n_s   = STALL_LOAD;
            end else begin
               state_n_s = DONE;
            end
         end
         W2: begin
            if (cnt_r == 4'd0) begin
               state_n_s = DONE;
            end else begin
               cnt_n_s = cnt_r - 4'd1;
            end
         end
         DONE:    state_n_s = IDLE;
         default: state_n_s = IDLE;
      endcase
   end

   // Moore decode of the upcoming state so every output leaves a flop.
   always_comb begin
      busy_s  = (state_n_s != IDLE);
      done_s  = (state_n_s == DONE);
      rain_s  = 1'b0;
      rbin_s  = 1'b0;
      rzin_s  = 1'b0;
      raout_s = 1'b0;
      rbout_s = 1'b0;
      case (state_n_s)
         T1: begin
            case (op_n_s)
               OP_LDI: rain_s = 1'b1;
               OP_MOV: begin
                  raout_s = 1'b1;
                  rbin_s  = 1'b1;
               end
               OP_ADD: begin
                  rbout_s = 1'b1;
                  rzin_s  = 1'b1;
               end
               default: rain_s = 1'b0;
            endcase
         end
         T2:      rbin_s = 1'b1;
         default: rbin_s = 1'b0;
      endcase
   end

   // State, opcode, counter and output registers.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_r <= IDLE;
         op_r    <= 2'b00;
         cnt_r   <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rain_r  <= 1'b0;
         rbin_r  <= 1'b0;
         rzin_r  <= 1'b0;
         raout_r <= 1'b0;
         rbout_r <= 1'b0;
      end else begin
         state_r <= state_n_s;
         op_r    <= op_n_s;
         cnt_r   <= cnt_n_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         rain_r  <= rain_s;
         rbin_r  <= rbin_s;
         rzin_r  <= rzin_s;
         raout_r <= raout_s;
         rbout_r <= rbout_s;
      end
   end

`ifdef SEQ_WRITEBACK_EN
   logic rzout_r;

   // Writeback bus drive, only present when the T2 step exists.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         rzout_r <= 1'b0;
      end else begin
         rzout_r <= (state_n_s == T2);
      end
   end

   assign RZout = rzout_r;
`else
   assign RZout = 1'b0;
`endif

   assign busy  = busy_r;
   assign done  = done_r;
   assign RAin  = rain_r;
   assign RBin  = rbin_r;
   assign RZin  = rzin_r;
   assign RAout = raout_r;
   assign RBout = rbout_r;

endmodule
